// File: rtl/mult_pkg.sv
// Shared types and constants for the shift-add multiplier.
// State encoding plus the legal operand width range.
package mult_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADD   = 3'd1,
    S_SHIFT = 3'd2,
    S_DONE  = 3'd3,
    S_ADDSH = 3'd4
  } state_t;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  function automatic bit width_ok(int w);
    return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
  endfunction

endpackage

// File: rtl/mult_control.sv
// Control FSM and bit counter of the shift-add multiplier.
// In: clk, rst_n, st, acc0. Out: last, idle, load, ad, sh, done.
module mult_control
  import mult_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int FAST  = 0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_st,
  input  logic i_acc0,
  output logic o_last,
  output logic o_idle,
  output logic o_load,
  output logic o_ad,
  output logic o_sh,
  output logic o_done
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == CW'(WIDTH - 1));
  assign o_last = w_last;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (o_load)
        r_cnt <= '0;
      else if (o_sh)
        r_cnt <= r_cnt + 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    o_idle = 1'b0;
    o_load = 1'b0;
    o_ad   = 1'b0;
    o_sh   = 1'b0;
    o_done = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        o_idle = 1'b1;
        o_load = i_st;
        if (i_st)
          w_next = (FAST != 0) ? S_ADDSH : S_ADD;
      end
      S_ADD: begin
        o_ad   = i_acc0;
        w_next = S_SHIFT;
      end
      S_SHIFT: begin
        o_sh   = 1'b1;
        w_next = w_last ? S_DONE : S_ADD;
      end
      S_ADDSH: begin
        o_ad   = i_acc0;
        o_sh   = 1'b1;
        w_next = w_last ? S_DONE : S_ADDSH;
      end
      S_DONE: begin
        o_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: rtl/shift_add_mult.sv
// Sequential shift-add multiplier, unsigned or two's complement.
// In: Clk, Rst_n, St, Sgn, Mplier, Mcand. Out: Idle, Load, Ad, Sh, Done, Product.
module shift_add_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int FAST  = 0
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               St,
  input  logic               Sgn,
  input  logic [WIDTH-1:0]   Mplier,
  input  logic [WIDTH-1:0]   Mcand,
  output logic               Idle,
  output logic               Load,
  output logic               Ad,
  output logic               Sh,
  output logic               Done,
  output logic [2*WIDTH-1:0] Product
);

  localparam int AW = 2 * WIDTH + 1;

  generate
    if (!width_ok(WIDTH)) begin : g_width_illegal
      $error("shift_add_mult: WIDTH out of range");
    end
  endgenerate

  logic [AW-1:0] r_acc;
  logic [WIDTH:0] r_mc;
  logic          r_sgn;

  logic          w_last;
  logic          w_load;
  logic          w_ad;
  logic          w_sh;
  logic [WIDTH:0] w_hi;
  logic [WIDTH:0] w_sum;
  logic [AW-1:0] w_added;
  logic [AW-1:0] w_shifted;
  logic          w_fill;

  mult_control #(
    .WIDTH (WIDTH),
    .FAST  (FAST)
  ) u_ctrl (
    .i_clk   (Clk),
    .i_rst_n (Rst_n),
    .i_st    (St),
    .i_acc0  (r_acc[0]),
    .o_last  (w_last),
    .o_idle  (Idle),
    .o_load  (w_load),
    .o_ad    (w_ad),
    .o_sh    (w_sh),
    .o_done  (Done)
  );

  assign Load = w_load;
  assign Ad   = w_ad;
  assign Sh   = w_sh;

  // Signed multiplier MSB carries weight -2^(W-1): subtract there.
  assign w_hi  = r_acc[AW-1:WIDTH];
  assign w_sum = (r_sgn && w_last) ? (w_hi - r_mc)
                                   : (w_hi + r_mc);

  assign w_added   = w_ad ? {w_sum, r_acc[WIDTH-1:0]}
                          : r_acc;
  assign w_fill    = r_sgn & w_added[AW-1];
  assign w_shifted = {w_fill, w_added[AW-1:1]};

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_acc <= '0;
      r_mc  <= '0;
      r_sgn <= 1'b0;
    end else if (w_load) begin
      r_acc <= {{(WIDTH+1){1'b0}}, Mplier};
      r_mc  <= {Sgn & Mcand[WIDTH-1], Mcand};
      r_sgn <= Sgn;
    end else if (w_sh) begin
      r_acc <= w_shifted;
    end else if (w_ad) begin
      r_acc <= w_added;
    end
  end

  assign Product = r_acc[2*WIDTH-1:0];

endmodule

// File: tb/tb_shift_add_mult.sv
// Randomised self-checking bench for shift_add_mult.
// Two instances: WIDTH=4/FAST=0 and WIDTH=8/FAST=1.
module tb_shift_add_mult;

  logic             clk;
  logic [1:0]       rst_n;
  logic [1:0]       st;
  logic [1:0]       sgn;
  logic [1:0][7:0]  mpl;
  logic [1:0][7:0]  mca;
  logic [1:0]       idle_o;
  logic [1:0]       load_o;
  logic [1:0]       ad_o;
  logic [1:0]       sh_o;
  logic [1:0]       done_o;
  logic [7:0]       pr0;
  logic [15:0]      pr1;

  int n_chk = 0;
  int n_fail = 0;

  int          t [2];
  bit          live [2];
  bit          known [2];
  logic [7:0]  m_a [2];
  logic [15:0] m_p [2];

  shift_add_mult #(.WIDTH(4), .FAST(0)) u4 (
    .Clk     (clk),
    .Rst_n   (rst_n[0]),
    .St      (st[0]),
    .Sgn     (sgn[0]),
    .Mplier  (mpl[0][3:0]),
    .Mcand   (mca[0][3:0]),
    .Idle    (idle_o[0]),
    .Load    (load_o[0]),
    .Ad      (ad_o[0]),
    .Sh      (sh_o[0]),
    .Done    (done_o[0]),
    .Product (pr0)
  );

  shift_add_mult #(.WIDTH(8), .FAST(1)) u8 (
    .Clk     (clk),
    .Rst_n   (rst_n[1]),
    .St      (st[1]),
    .Sgn     (sgn[1]),
    .Mplier  (mpl[1]),
    .Mcand   (mca[1]),
    .Idle    (idle_o[1]),
    .Load    (load_o[1]),
    .Ad      (ad_o[1]),
    .Sh      (sh_o[1]),
    .Done    (done_o[1]),
    .Product (pr1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] get_pr(int id);
    return (id == 0) ? {8'h00, pr0} : pr1;
  endfunction

  // Reference product: plain integer multiply of the operands.
  function automatic logic [15:0] prod(int w, bit sg,
                                       logic [7:0] a,
                                       logic [7:0] b);
    longint x;
    longint y;
    longint p;
    longint m;
    m = (64'd1 << w) - 1;
    x = longint'(a) & m;
    y = longint'(b) & m;
    if (sg && x[w-1]) x = x - (64'd1 << w);
    if (sg && y[w-1]) y = y - (64'd1 << w);
    p = x * y;
    p = p & ((64'd1 << (2 * w)) - 1);
    return p[15:0];
  endfunction

  task automatic chk(string nm, int id,
                     logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[dut%0d] t=%0t: got %0h expected %0h",
               nm, id, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the cycle-index model.
  always @(negedge clk) begin
    for (int id = 0; id < 2; id++) begin
      int   w;
      int   l;
      int   tt;
      logic eidle;
      logic eload;
      logic ead;
      logic esh;
      logic edone;
      w  = (id == 0) ? 4 : 8;
      l  = (id == 0) ? 2 * w + 1 : w + 1;
      tt = t[id];
      if (live[id]) begin
        eidle = (tt == 0);
        eload = eidle && st[id];
        ead   = 1'b0;
        esh   = 1'b0;
        if (id == 0) begin
          if (tt >= 1 && tt <= 2 * w) begin
            if (tt % 2 == 1) ead = m_a[id][(tt - 1) / 2];
            else             esh = 1'b1;
          end
        end else begin
          if (tt >= 1 && tt <= w) begin
            ead = m_a[id][tt - 1];
            esh = 1'b1;
          end
        end
        edone = (tt == l);
        chk("idle", id, 32'(idle_o[id]), 32'(eidle));
        chk("load", id, 32'(load_o[id]), 32'(eload));
        chk("ad",   id, 32'(ad_o[id]),   32'(ead));
        chk("sh",   id, 32'(sh_o[id]),   32'(esh));
        chk("done", id, 32'(done_o[id]), 32'(edone));
        if (edone || (eidle && known[id]))
          chk("product", id, 32'(get_pr(id)), 32'(m_p[id]));
      end
      if (!rst_n[id]) begin
        live[id]  = 1'b1;
        t[id]     = 0;
        m_p[id]   = '0;
        known[id] = 1'b1;
      end else if (tt == 0) begin
        if (st[id]) begin
          t[id]     = 1;
          m_a[id]   = mpl[id];
          m_p[id]   = prod(w, sgn[id], mpl[id], mca[id]);
          known[id] = 1'b0;
        end
      end else if (tt == l) begin
        t[id]     = 0;
        known[id] = 1'b1;
      end else begin
        t[id] = tt + 1;
      end
    end
  end

  // Start one operation from IDLE; returns with the DUT idle again.
  task automatic run_op(input int id, input bit sg,
                        input logic [7:0] a, input logic [7:0] b,
                        input bit use_lit, input logic [15:0] lit,
                        input int lat, input int lit_ad,
                        input int lit_sh);
    int cyc;
    int nad;
    int nsh;
    bit seen;
    cyc  = 0;
    nad  = 0;
    nsh  = 0;
    seen = 1'b0;
    st[id]  = 1'b1;
    sgn[id] = sg;
    mpl[id] = a;
    mca[id] = b;
    @(posedge clk); #1;
    st[id]  = 1'b0;
    sgn[id] = 1'($urandom);
    mpl[id] = 8'($urandom);
    mca[id] = 8'($urandom);
    cyc = 1;
    while (!seen && cyc < 100) begin
      if (ad_o[id]) nad++;
      if (sh_o[id]) nsh++;
      if (done_o[id]) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    chk("done_seen", id, 32'(seen), 32'd1);
    if (use_lit) begin
      chk("lit_product", id, 32'(get_pr(id)), 32'(lit));
      chk("lit_latency", id, 32'(cyc), 32'(lat));
      if (lit_ad >= 0) chk("lit_ad_count", id, 32'(nad), 32'(lit_ad));
      if (lit_sh >= 0) chk("lit_sh_count", id, 32'(nsh), 32'(lit_sh));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int dones;
    int k;
    int cyc;
    for (int i = 0; i < 2; i++) begin
      t[i] = 0;
      live[i] = 1'b0;
      known[i] = 1'b0;
      m_a[i] = '0;
      m_p[i] = '0;
    end
    rst_n = 2'b00;
    st    = 2'b00;
    sgn   = 2'b00;
    mpl   = '0;
    mca   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_idle", 0, 32'(idle_o[0]), 32'd1);
    chk("reset_product", 1, 32'(pr1), 32'd0);
    rst_n = 2'b11;
    @(posedge clk); #1;

    run_op(0, 0, 8'd13, 8'd11, 1, 16'h008F, 9, 3, 4);
    run_op(0, 1, 8'h0D, 8'd5,  1, 16'h00F1, 9, -1, 4);
    run_op(0, 1, 8'h08, 8'h08, 1, 16'h0040, 9, 1, 4);
    run_op(0, 0, 8'd0,  8'd15, 1, 16'h0000, 9, 0, 4);
    run_op(1, 0, 8'hFF, 8'hFF, 1, 16'hFE01, 9, 8, 8);
    run_op(1, 1, 8'h80, 8'h7F, 1, 16'hC080, 9, 1, 8);

    // St held high: restart after one IDLE cycle each time.
    dones = 0;
    k = 0;
    cyc = 0;
    st[0]  = 1'b1;
    sgn[0] = 1'b0;
    mpl[0] = 8'd13;
    mca[0] = 8'd11;
    while (dones < 4 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (done_o[0]) dones++;
      if (idle_o[0]) begin
        k++;
        sgn[0] = k[0];
        mpl[0] = k[0] ? 8'h09 : 8'd13;
        mca[0] = k[0] ? 8'h07 : 8'd11;
      end
    end
    chk("b2b_dones", 0, 32'(dones), 32'd4);
    st[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Reset in cycle 3 of a run.
    st[0]  = 1'b1;
    sgn[0] = 1'b0;
    mpl[0] = 8'd13;
    mca[0] = 8'd11;
    @(posedge clk); #1;
    st[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n[0] = 1'b0;
    @(posedge clk); #1;
    chk("rst_idle",    0, 32'(idle_o[0]), 32'd1);
    chk("rst_product", 0, 32'(pr0),       32'd0);
    chk("rst_done",    0, 32'(done_o[0]), 32'd0);
    rst_n[0] = 1'b1;
    run_op(0, 0, 8'd13, 8'd11, 1, 16'h008F, 9, 3, 4);

    for (int i = 0; i < 60; i++) begin
      int id;
      id = int'($urandom_range(0, 1));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      run_op(id, 1'($urandom), 8'($urandom), 8'($urandom),
             0, 16'h0, 0, -1, -1);
    end

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
